// File: rtl/fnn_ctrl_pkg.sv
// Shared state encoding and parameter defaults for the layer sequencing controller.
package fnn_ctrl_pkg;

  localparam int NN_DEFAULT       = 10;
  localparam int WD_LIMIT_DEFAULT = 4095;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_COMPUTE,
    ST_SHIFT,
    ST_WAITV,
    ST_RESTART,
    ST_DONE,
    ST_ERR
  } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Saturating watchdog counter. expired flags the enabled cycle whose increment
// reaches LIMIT, so the controller can leave on that same edge.
module seq_watchdog #(
  parameter int LIMIT = 4095,
  parameter int CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_W'(LIMIT))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expired = en && (cnt >= CNT_W'(LIMIT - 1));

endmodule

// File: rtl/layer_sequencer.sv
// Runs one inference pass of a neuron layer: start, compute, paced word
// shift-out, restart handshake, with a watchdog guarding the waiting states.
//
// state   | meaning
// IDLE    | waiting for go with layer_ready
// START   | start strobe out, word_idx and watchdog cleared
// COMPUTE | waiting for neurons_finished, watchdog running
// SHIFT   | waiting for dn_ready to issue the next shift
// WAITV   | layer SOUT word valid, pick next shift or restart
// RESTART | restart held until transferred rises and falls
// DONE    | one-cycle completion pulse
// ERR     | watchdog expired, timeout held until reset
module layer_sequencer
  import fnn_ctrl_pkg::*;
#(
  parameter int NN       = NN_DEFAULT,
  parameter int WD_LIMIT = WD_LIMIT_DEFAULT,
  parameter int IDX_W    = $clog2(NN + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             go,
  input  logic             layer_ready,
  input  logic             neurons_finished,
  input  logic             transferred,
  input  logic             dn_ready,
  output logic             start,
  output logic             shift,
  output logic             restart,
  output logic             sout_valid,
  output logic [IDX_W-1:0] word_idx,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  seq_state_e state;
  logic       xfer_seen;
  logic       idx_full;
  logic       wd_clr;
  logic       wd_en;
  logic       wd_expired;

  assign idx_full = (word_idx == IDX_W'(NN));
  assign wd_clr   = (state == ST_START) || (state == ST_WAITV);
  assign wd_en    = ((state == ST_COMPUTE) && !neurons_finished) ||
                    ((state == ST_RESTART) && !xfer_seen && !transferred);

  seq_watchdog #(.LIMIT(WD_LIMIT)) u_wd (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  // Outputs are assigned alongside the transition, so each reflects the state being entered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      start      <= 1'b0;
      shift      <= 1'b0;
      restart    <= 1'b0;
      sout_valid <= 1'b0;
      word_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      xfer_seen  <= 1'b0;
    end else begin
      start      <= 1'b0;
      shift      <= 1'b0;
      sout_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go && layer_ready) begin
            state    <= ST_START;
            start    <= 1'b1;
            busy     <= 1'b1;
            word_idx <= '0;
          end
        end
        ST_START: state <= ST_COMPUTE;
        ST_COMPUTE: begin
          if (neurons_finished) begin
            state <= ST_SHIFT;
          end else if (wd_expired) begin
            state   <= ST_ERR;
            timeout <= 1'b1;
            restart <= 1'b1;
          end
        end
        ST_SHIFT: begin
          if (dn_ready && !idx_full) begin
            state    <= ST_WAITV;
            shift    <= 1'b1;
            word_idx <= word_idx + IDX_W'(1);
          end
        end
        ST_WAITV: begin
          sout_valid <= 1'b1;
          if (idx_full) begin
            state     <= ST_RESTART;
            restart   <= 1'b1;
            xfer_seen <= 1'b0;
          end else begin
            state <= ST_SHIFT;
          end
        end
        ST_RESTART: begin
          if (transferred) begin
            xfer_seen <= 1'b1;
          end else if (xfer_seen) begin
            state   <= ST_DONE;
            restart <= 1'b0;
            done    <= 1'b1;
          end else if (wd_expired) begin
            state   <= ST_ERR;
            timeout <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_ERR: restart <= 1'b0;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: pass-configuration table, hand-written
// reset/watchdog sequences and randomized passes against a timing model.
module tb_layer_sequencer;

  localparam int NN     = 10;
  localparam int WDL    = 50;
  localparam int IW     = $clog2(NN + 1);
  localparam int BUDGET = 400;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          go = 1'b0;
  logic          layer_ready = 1'b0;
  logic          neurons_finished = 1'b0;
  logic          transferred = 1'b0;
  logic          dn_ready = 1'b0;
  logic          start, shift, restart, sout_valid, busy, done, timeout;
  logic [IW-1:0] word_idx;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit ready;
    int fin;
    int stall_pct;
    int stall_after;
    int stall_len;
    int xw;
    int xl;
    bit noise;
  } pass_t;

  int shifts[$];
  bit dn_hist [BUDGET];
  int n_start, n_busy, n_valid, v_idx, v_valid, v_rst, rs, done_i, to_i, widx_done;

  layer_sequencer #(.NN(NN), .WD_LIMIT(WDL)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .go               (go),
    .layer_ready      (layer_ready),
    .neurons_finished (neurons_finished),
    .transferred      (transferred),
    .dn_ready         (dn_ready),
    .start            (start),
    .shift            (shift),
    .restart          (restart),
    .sout_valid       (sout_valid),
    .word_idx         (word_idx),
    .busy             (busy),
    .done             (done),
    .timeout          (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int outs_word();
    return 32'({start, shift, restart, sout_valid, busy, done, timeout, word_idx});
  endfunction

  // Sits in the error state, confirming it is sticky and deaf to go, then resets.
  task automatic err_hold();
    int n_r, n_s, n_b, n_t;
    n_r = 0; n_s = 0; n_b = 0; n_t = 0;
    tick();
    for (int i = 0; i < 12; i++) begin
      if (restart) n_r++;
      if (start)   n_s++;
      if (busy)    n_b++;
      if (timeout) n_t++;
      go = (i % 3 == 0);
      tick();
    end
    go = 1'b0;
    check("err_restart_after_entry", n_r, 0);
    check("err_no_start", n_s, 0);
    check("err_busy", n_b, 12);
    check("err_timeout_sticky", n_t, 12);
    rstn = 1'b0;
    tick();
    check("err_reset_clears", outs_word(), 0);
    rstn = 1'b1;
  endtask

  task automatic run_and_check(input pass_t p);
    int  stall_left, exp_t, mism;
    bit  prev_shift;
    shifts.delete();
    foreach (dn_hist[j]) dn_hist[j] = 1'b0;
    n_start = 0; n_busy = 0; n_valid = 0; v_idx = 0; v_valid = 0; v_rst = 0;
    rs = -1; done_i = -1; to_i = -1; widx_done = -1;
    stall_left = 0; prev_shift = 1'b0;
    layer_ready = p.ready; neurons_finished = 1'b0; transferred = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    // cycle i = 0 is the first cycle after go was sampled
    for (int i = 0; i < BUDGET; i++) begin
      if (start) n_start++;
      if (busy)  n_busy++;
      if (sout_valid) begin
        n_valid++;
        if (!prev_shift) v_valid++;
      end
      if (shift) begin
        shifts.push_back(i);
        if (int'(word_idx) != shifts.size()) v_idx++;
      end
      if (rs >= 0 && !restart && !done) v_rst++;
      if (restart && rs < 0) rs = i;
      if (done) begin
        done_i = i;
        widx_done = int'(word_idx);
        if (restart) v_rst++;
        break;
      end
      if (timeout) begin
        to_i = i;
        break;
      end
      if (!p.ready && i >= 8) break;
      prev_shift = shift;
      neurons_finished = (i >= p.fin);
      if (p.stall_after > 0 && shift && int'(word_idx) == p.stall_after) stall_left = p.stall_len;
      if (stall_left > 0) begin
        dn_ready = 1'b0;
        stall_left--;
      end else begin
        dn_ready = (int'($urandom_range(99)) >= p.stall_pct);
      end
      dn_hist[i] = dn_ready;
      transferred = (rs >= 0) && (i - rs >= p.xw) && (i - rs < p.xw + p.xl);
      go = p.noise && ($urandom_range(2) == 0);
      tick();
    end
    go = 1'b0;

    if (!p.ready) begin
      check("not_ready_start", n_start, 0);
      check("not_ready_busy", n_busy, 0);
      return;
    end
    check("start_count", n_start, 1);
    if (p.fin > WDL) begin
      check("compute_wd_cycle", to_i, WDL + 1);
      check("compute_wd_shifts", shifts.size(), 0);
      check("compute_wd_restart", rs, WDL + 1);
      err_hold();
      return;
    end
    // A shift appears one cycle after the first dn_ready=1 cycle at or after it
    // becomes eligible; the next one is eligible two cycles after that.
    exp_t = p.fin + 1;
    mism = 0;
    for (int k = 0; k < NN; k++) begin
      while (exp_t < BUDGET - 1 && !dn_hist[exp_t]) exp_t++;
      if (k >= shifts.size() || shifts[k] != exp_t + 1) mism++;
      exp_t += 2;
    end
    check("shift_times", mism, 0);
    check("shift_count", shifts.size(), NN);
    check("valid_count", n_valid, NN);
    check("valid_follows_shift", v_valid, 0);
    check("idx_tracks_shifts", v_idx, 0);
    check("restart_cycle", rs, exp_t);
    check("restart_held", v_rst, 0);
    if (p.xl == 0) begin
      check("stuck_restart_wd_cycle", to_i, exp_t + WDL);
      err_hold();
      return;
    end
    check("done_cycle", done_i, exp_t + p.xw + p.xl + 1);
    check("idx_final", widx_done, NN);
    go = p.noise;
    tick();
    go = 1'b0;
    check("go_on_done_ignored", 32'({busy, start}), 0);
  endtask

  task automatic mid_reset(input int at_shift);
    bit hit;
    hit = 1'b0;
    layer_ready = 1'b1; dn_ready = 1'b1; transferred = 1'b0; neurons_finished = 1'b0;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (at_shift > 0 ? (shift && int'(word_idx) == at_shift) : restart) begin
        hit = 1'b1;
        break;
      end
      neurons_finished = (i >= 3);
      tick();
    end
    check("midreset_reached", hit, 1);
    rstn = 1'b0;
    tick();
    check("midreset_outputs", outs_word(), 0);
    rstn = 1'b1;
    neurons_finished = 1'b0;
  endtask

  initial begin
    pass_t vec [8];
    pass_t p;

    vec = '{
      '{1'b1, 20,      0,  0, 0, 0, 1, 1'b0},
      '{1'b1, 20,      0,  3, 5, 2, 3, 1'b0},
      '{1'b0, 1,       0,  0, 0, 0, 1, 1'b0},
      '{1'b1, 5,       0,  0, 0, 1, 2, 1'b1},
      '{1'b1, WDL,     0,  0, 0, 0, 1, 1'b0},
      '{1'b1, WDL + 1, 0,  0, 0, 0, 1, 1'b0},
      '{1'b1, 4,       0,  0, 0, 3, 0, 1'b0},
      '{1'b1, 2,       30, 0, 0, 0, 2, 1'b1}
    };

    rstn = 1'b0; go = 1'b1; layer_ready = 1'b1;
    tick();
    tick();
    check("reset_outputs", outs_word(), 0);
    go = 1'b0;
    rstn = 1'b1;
    tick();
    check("idle_after_reset", outs_word(), 0);

    foreach (vec[k]) run_and_check(vec[k]);

    p = '{1'b1, 7, 0, 0, 0, 0, 1, 1'b0};
    mid_reset(4);
    run_and_check(p);
    mid_reset(0);
    run_and_check(p);

    repeat (12) begin
      p.ready       = 1'b1;
      p.fin         = int'($urandom_range(40, 1));
      p.stall_pct   = int'($urandom_range(60, 0));
      p.stall_after = 0;
      p.stall_len   = 0;
      p.xw          = int'($urandom_range(10, 0));
      p.xl          = int'($urandom_range(5, 1));
      p.noise       = ($urandom_range(1) == 1);
      run_and_check(p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter NN, default 10, the number of neurons (output words) in the controlled layer.
REQ-002 SHALL have parameter WD_LIMIT, default 4095, the maximum COMPUTE cycles before timeout.
REQ-003 SHALL have parameter IDX_W, default $clog2(NN+1), the width of word_idx.
REQ-004 Port clk, input, 1: the single clock; every flop SHALL update on its rising edge.
REQ-005 Port rstn, input, 1: synchronous, active-low reset.
REQ-006 Port go, input, 1: request one inference pass.
REQ-007 Port layer_ready, input, 1: the layer's weights are all loaded.
REQ-008 Port neurons_finished, input, 1: all neurons of the layer have finished.
REQ-009 Port transferred, input, 1: the layer has shifted out all NN words.
REQ-010 Port dn_ready, input, 1: the downstream consumer can accept one word.
REQ-011 Port start, output, 1: the layer's start strobe.
REQ-012 Port shift, output, 1: the layer's shift strobe.
REQ-013 Port restart, output, 1: the layer's restart request.
REQ-014 Port sout_valid, output, 1: the layer's SOUT word is valid this cycle.
REQ-015 Port word_idx, output, IDX_W: the number of shifts issued in the current pass.
REQ-016 Port busy, output, 1: the block is in any state other than IDLE.
REQ-017 Port done, output, 1: one-cycle pass-complete pulse.
REQ-018 Port timeout, output, 1: sticky watchdog error flag.

Function
REQ-019 All outputs SHALL be registered, with no combinational path from any input to any output.
REQ-020 The FSM SHALL have states IDLE, START, COMPUTE, SHIFT, WAITV, RESTART, DONE and ERR.
REQ-021 IDLE: on go=1 and layer_ready=1 the FSM SHALL enter START; go with layer_ready=0 SHALL be dropped, not queued.
REQ-022 START: start SHALL be 1 for exactly one cycle, word_idx SHALL clear to 0, and the watchdog SHALL clear; next state COMPUTE.
REQ-023 COMPUTE: on neurons_finished=1 the FSM SHALL enter SHIFT; otherwise the watchdog SHALL increment each cycle.
REQ-024 COMPUTE: when the watchdog reaches WD_LIMIT the FSM SHALL enter ERR.
REQ-025 SHIFT: with dn_ready=1 and word_idx<NN, shift SHALL be 1 for one cycle and word_idx SHALL increment; next state WAITV.
REQ-026 SHIFT: with dn_ready=0 the FSM SHALL hold and shift SHALL stay 0 (stall).
REQ-027 WAITV: sout_valid SHALL be 1 for exactly one cycle, the cycle after the shift pulse (the layer updates SOUT on the falling edge).
REQ-028 WAITV: next state SHALL be SHIFT if word_idx<NN, otherwise RESTART.
REQ-029 Two shift pulses SHALL always be separated by at least one cycle; shift SHALL never be asserted more than NN times per pass.
REQ-030 RESTART: restart SHALL be held at 1 until transferred=1 has been seen and has then returned to 0; the FSM SHALL then enter DONE.
REQ-031 RESTART: if transferred is already 0 on entry and was never seen as 1, the FSM SHALL stay in RESTART (stuck-pass) and the watchdog SHALL run; reaching WD_LIMIT SHALL enter ERR.
REQ-032 DONE: done SHALL be 1 for one cycle; next state IDLE.
REQ-033 ERR: timeout SHALL be 1, and restart SHALL be 1 for one cycle on entry; the FSM SHALL remain in ERR until rstn=0.
REQ-034 go while busy=1 SHALL be ignored, with no effect on the current pass.
REQ-035 A go arriving in the same cycle as the done pulse SHALL be ignored; go in the next cycle (IDLE) SHALL be accepted.
REQ-036 The watchdog SHALL saturate at WD_LIMIT and SHALL never wrap.
REQ-037 word_idx SHALL count 0..NN and SHALL never wrap within a pass.

Reset
REQ-038 With rstn=0 at a rising clk edge, the FSM SHALL go to IDLE and all outputs, word_idx, the watchdog and timeout SHALL go to 0, regardless of the current state, including mid-SHIFT or RESTART.
REQ-039 Reset SHALL NOT drive restart; the layer is reset by its own reset pin.

Structure
REQ-040 Package fnn_ctrl_pkg SHALL hold the FSM state enum, the default NN and the default WD_LIMIT.
REQ-041 A single sub-module seq_watchdog SHALL provide the watchdog: a saturating counter with clear/enable inputs and an expired output.

Verification
REQ-042 NN=10, layer_ready=1, go pulse, neurons_finished after 20 cycles, dn_ready=1 -> exactly 1 start, then 10 shift pulses each followed by sout_valid, word_idx=10, restart held until transferred falls, then 1 done pulse.
REQ-043 As REQ-042 with dn_ready=0 for 5 cycles after the 3rd shift -> no shift during the stall, word_idx stays 3, and shifting resumes when dn_ready returns to 1.
REQ-044 go with layer_ready=0 -> busy stays 0 and start is never asserted; a later go with layer_ready=1 -> a normal pass.
REQ-045 WD_LIMIT=50 with neurons_finished held at 0 -> timeout=1 at cycle 50 of COMPUTE, one restart pulse, and the FSM held in ERR until rstn=0.
REQ-046 rstn=0 after the 4th shift -> all outputs 0 on the next edge; a subsequent go -> a full pass with word_idx counting from 0.
REQ-047 go pulsed during COMPUTE and again on the done cycle -> ignored both times, and exactly one done per accepted go.
